// File: rtl/ltc2308_pkg.sv
// ============================================================================
// ltc2308_pkg : config-word layout, FSM states and code conversion helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package ltc2308_pkg;

  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  localparam logic [5:0] DEFAULT_CFG = 6'b100010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  function automatic logic [2:0] cfg_to_channel(input logic [5:0] cfg);
    return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
  endfunction

  // Differential mode reuses the single-ended channel as the positive input
  // and flips its LSB for the negative input.
  function automatic logic [11:0] compute_code(input logic [5:0]  cfg,
                                               input logic [95:0] samples);
    logic [2:0]         ch_a;
    logic [2:0]         ch_b;
    logic [11:0]        a;
    logic [11:0]        b;
    logic signed [12:0] d;
    logic [11:0]        code;
    ch_a = cfg_to_channel(cfg);
    ch_b = {ch_a[2:1], ~ch_a[0]};
    a    = samples[int'(ch_a)*12 +: 12];
    b    = samples[int'(ch_b)*12 +: 12];
    d    = $signed({1'b0, a}) - $signed({1'b0, b});
    if (cfg[CFG_SD]) begin
      code = cfg[CFG_UNI] ? a : (a ^ 12'h800);
    end else if (cfg[CFG_UNI]) begin
      code = d[12] ? 12'h000 : d[11:0];
    end else begin
      code = d[12:1];
    end
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ltc2308_sync_edge.sv
// ============================================================================
// ltc2308_sync_edge : 2-FF synchronizer with registered rise/fall pulses
// Rev 1.0
// ============================================================================
`default_nettype none

module ltc2308_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic dly_q;
  logic rise_q;
  logic fall_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
      rise_q <= sync_q & ~dly_q;
      fall_q <= ~sync_q & dly_q;
    end
  end

  // Delayed level lines up in time with the edge pulses of sibling instances.
  assign level_o = dly_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

`default_nettype wire

// File: rtl/ltc2308_responder.sv
// ============================================================================
// ltc2308_responder : device-side LTC2308 SPI model with pipelined config
// Rev 1.0
// ============================================================================
`default_nettype none

module ltc2308_responder #(
  parameter int unsigned CONV_CYCLES = 80,
  parameter logic [5:0]  DEFAULT_CFG = ltc2308_pkg::DEFAULT_CFG
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        adc_convst,
  input  logic        adc_sck,
  input  logic        adc_sdi,
  output logic        adc_sdo,
  input  logic [95:0] ch_sample,
  output logic        busy,
  output logic        frame_done,
  output logic [5:0]  cfg_rx,
  output logic        err_overrun,
  output logic        err_early_sck
);

  import ltc2308_pkg::*;

  localparam int              CNT_W    = $clog2(CONV_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);

  logic convst_rise;
  logic convst_fall;
  logic convst_lvl;
  logic sck_rise;
  logic sck_fall;
  logic sck_lvl;
  logic sdi_lvl;
  logic sdi_rise;
  logic sdi_fall;
  logic convst_unused;
  logic sdi_unused;

  ltc2308_sync_edge u_sync_convst (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (adc_convst),
    .level_o (convst_lvl),
    .rise_o  (convst_rise),
    .fall_o  (convst_fall)
  );

  ltc2308_sync_edge u_sync_sck (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (adc_sck),
    .level_o (sck_lvl),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  ltc2308_sync_edge u_sync_sdi (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (adc_sdi),
    .level_o (sdi_lvl),
    .rise_o  (sdi_rise),
    .fall_o  (sdi_fall)
  );

  assign convst_unused = convst_lvl | convst_fall | sck_lvl;
  assign sdi_unused    = sdi_rise | sdi_fall;

  state_e           state_q;
  logic [CNT_W-1:0] conv_cnt_q;
  logic [5:0]       active_cfg_q;
  logic [5:0]       pending_cfg_q;
  logic [5:0]       cfg_rx_q;
  logic [95:0]      samples_q;
  logic [11:0]      result_q;
  logic [2:0]       rx_cnt_q;
  logic [3:0]       tx_cnt_q;
  logic [5:0]       rx_shift_q;
  logic             sdo_q;
  logic             busy_q;
  logic             frame_done_q;
  logic             err_overrun_q;
  logic             err_early_sck_q;

  logic [11:0]      code_d;
  logic [5:0]       rx_shift_d;

  assign code_d     = compute_code(active_cfg_q, samples_q);
  assign rx_shift_d = {rx_shift_q[4:0], sdi_lvl};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      conv_cnt_q      <= '0;
      active_cfg_q    <= DEFAULT_CFG;
      pending_cfg_q   <= DEFAULT_CFG;
      cfg_rx_q        <= DEFAULT_CFG;
      samples_q       <= '0;
      result_q        <= '0;
      rx_cnt_q        <= '0;
      tx_cnt_q        <= '0;
      rx_shift_q      <= '0;
      sdo_q           <= 1'b0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      err_overrun_q   <= 1'b0;
      err_early_sck_q <= 1'b0;
    end else begin
      frame_done_q    <= 1'b0;
      err_overrun_q   <= 1'b0;
      err_early_sck_q <= 1'b0;
      case (state_q)
        ST_CONV: begin
          if (convst_rise) err_overrun_q   <= 1'b1;
          if (sck_rise)    err_early_sck_q <= 1'b1;
          if (conv_cnt_q == '0) begin
            result_q <= code_d;
            sdo_q    <= code_d[11];
            busy_q   <= 1'b0;
            state_q  <= ST_SHIFT;
          end else begin
            conv_cnt_q <= conv_cnt_q - 1'b1;
          end
        end
        default: begin
          // CONVST has priority over any SCK edge arriving in the same cycle.
          if (convst_rise) begin
            active_cfg_q <= pending_cfg_q;
            samples_q    <= ch_sample;
            conv_cnt_q   <= CNT_LOAD;
            busy_q       <= 1'b1;
            sdo_q        <= 1'b0;
            rx_cnt_q     <= '0;
            tx_cnt_q     <= '0;
            rx_shift_q   <= '0;
            state_q      <= ST_CONV;
          end else if (state_q == ST_SHIFT) begin
            if (sck_rise && rx_cnt_q < 3'd6) begin
              rx_shift_q <= rx_shift_d;
              rx_cnt_q   <= rx_cnt_q + 1'b1;
              if (rx_cnt_q == 3'd5) begin
                pending_cfg_q <= rx_shift_d;
                cfg_rx_q      <= rx_shift_d;
                frame_done_q  <= 1'b1;
              end
            end
            if (sck_fall) begin
              if (tx_cnt_q < 4'd11) begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
                sdo_q    <= result_q[4'd10 - tx_cnt_q];
              end else begin
                sdo_q <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

  assign adc_sdo       = sdo_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign cfg_rx        = cfg_rx_q;
  assign err_overrun   = err_overrun_q;
  assign err_early_sck = err_early_sck_q;

endmodule

`default_nettype wire

// File: doc/ltc2308_responder.md
Name: ltc2308_responder

Overview:
- Behavioural-synthesizable LTC2308 SPI responder: the device end of the 4-wire ADC link (CONVST/SCK/SDI in, SDO out) that our ADC controller drives as initiator.
- Returns 12-bit codes from eight parallel channel sample inputs, honouring the 6-bit config word, conversion time and pipelined channel selection.
- Used in board-less simulation of the ADC subsystem and as a GPIO-loopback target on a second DE1-SoC.

Parameters:
- CONV_CYCLES, 80, clk cycles from CONVST rise to data-valid (1.6 us at 50 MHz).
- DEFAULT_CFG, 6'b100010, config applied before the first received word (single-ended CH0, unipolar).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  synchronous, active-low reset.
- adc_convst  in  1  CONVST from initiator, asynchronous.
- adc_sck  in  1  SCK from initiator, asynchronous, at most clk/4.
- adc_sdi  in  1  SDI from initiator, asynchronous.
- adc_sdo  out  1  serial result, MSB first.
- ch_sample  in  96  eight 12-bit samples; CHn = [12n+11:12n].
- busy  out  1  high while converting.
- frame_done  out  1  one-cycle pulse when the 6th SDI bit is captured.
- cfg_rx  out  6  last complete config word {S/D,O/S,S1,S0,UNI,SLP}.
- err_overrun  out  1  one-cycle pulse on CONVST rise during CONV.
- err_early_sck  out  1  one-cycle pulse on SCK rise during CONV.

Behaviour:
- Inputs pass a 2-FF synchronizer, then a registered edge detector. Pin-to-internal-edge latency is 3 clk cycles.
- Reset: state=IDLE, adc_sdo=0, busy=0, frame_done=0, err_*=0, cfg_rx=DEFAULT_CFG, active_cfg=DEFAULT_CFG, result=0, bit counters=0. Reset mid-frame aborts the frame; the partial config is discarded.
- FSM states are IDLE, CONV and SHIFT.
- IDLE/SHIFT -> CONV on CONVST rise:
  - pending_cfg is copied to active_cfg and ch_sample is latched.
  - The conversion counter is loaded with CONV_CYCLES-1 and busy=1.
  - The config received in frame N therefore selects the conversion started at the next CONVST (LTC2308 pipelining).
- CONV:
  - The counter decrements each cycle.
  - At 0: compute result from active_cfg and the latched samples, then go to SHIFT, busy=0, and drive adc_sdo=result[11] in the same cycle.
  - CONVST rise during CONV: ignored, err_overrun pulses.
  - SCK edges during CONV: ignored, err_early_sck pulses on rises.
- SHIFT, SCK rise:
  - If rx_cnt<6: shift adc_sdi into rx_shift (MSB first) and increment rx_cnt.
  - When rx_cnt reaches 6: pending_cfg=cfg_rx=rx_shift and frame_done pulses.
  - Further SDI bits in the frame are ignored.
- SHIFT, SCK fall:
  - If tx_cnt<11: increment tx_cnt and drive adc_sdo=result[10-tx_cnt_old].
  - After bit 0 has been presented, the next fall drives adc_sdo=0 for the rest of the frame.
- Entry to CONV clears rx_cnt, tx_cnt and rx_shift. A frame with fewer than 6 SCK rises leaves pending_cfg unchanged.
- Channel map, single-ended (S/D=1): ch = {S1,S0,O/S}.
- Single-ended codes:
  - UNI=1: code = sample.
  - UNI=0: code = sample ^ 12'h800 (offset-binary to two's complement).
- Differential (S/D=0): pair p={S1,S0}; a=CH(2p+O/S), b=CH(2p+!O/S); d = a-b as 13-bit signed.
  - UNI=1: code = d<0 ? 0 : d[11:0].
  - UNI=0: code = d>>>1 (arithmetic shift), 12-bit two's complement.
- SLP is recorded in cfg_rx only and has no functional effect.
- Simultaneous CONVST rise and SCK edge in SHIFT: CONVST wins and the SCK edge is dropped.

Decomposition:
- Package ltc2308_pkg holds:
  - CFG bit-index constants (CFG_SD=5 … CFG_SLP=0).
  - DEFAULT_CFG.
  - The state enum.
  - A function cfg_to_channel(cfg) returning 3 bits.
  - A function compute_code(cfg, samples) returning 12 bits.
- Sub-module ltc2308_sync_edge: 2-FF synchronizer plus rise/fall pulse outputs, instantiated for convst, sck and sdi (sdi uses the level output only).

Test Plan:
- Reset then CONVST pulse with CH0=12'hA5C → busy high 80 cycles; 12 SCK falls shift out 1010_0101_1100; later bits 0; cfg_rx=6'b100010.
- Frame 1 sends SDI 6'b111010 (SE CH5 unipolar), CH5=12'h3F0 → frame_done once; frame 1 still returns CH0; frame 2 returns 12'h3F0.
- Config 6'b100000 (SE CH0 bipolar), CH0=12'h000 → code 12'h800; CH0=12'hFFF → 12'h7FF.
- Differential 6'b000000, CH0=12'h400, CH1=12'h600, UNI=0 → 12'hF00; with UNI=1 (6'b000010) → 12'h000.
- CONVST re-pulsed 20 cycles into CONV and SCK toggled during CONV → err_overrun=1 cycle, err_early_sck pulses; conversion completes at original cycle 80 with unchanged result.
- reset_n low mid-SHIFT after 3 SDI bits → adc_sdo=0, state IDLE, cfg_rx=6'b100010; next frame uses the default config.
